// File: rtl/adder_nbits_staged.sv
// adder_nbits_staged: WIDTH-bit adder with elastic valid/ready handshake, optionally
// pipelined CHUNK bits per stage when CLOCK_FREQUENCY exceeds HIGH_SPEED.
// Define ADDER_OVERFLOW_EN to register a signed-overflow flag alongside the sum;
// without it ovf is tied low and no overflow logic exists.
module adder_nbits_staged #(
    parameter int WIDTH           = 8,
    parameter int CHUNK           = 4,
    parameter int CLOCK_FREQUENCY = 100,
    parameter int HIGH_SPEED      = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             ovf
);
    localparam bit PIPE = CLOCK_FREQUENCY > HIGH_SPEED;

    logic             adv;
    logic             fin_v;
    logic             fin_c;
    logic [WIDTH-1:0] fin_s;
`ifdef ADDER_OVERFLOW_EN
    logic             fin_m;
`endif

    // one global enable: the whole pipe moves unless a finished result is blocked
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    if (WIDTH % CHUNK != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
        $error("adder_nbits_staged: WIDTH must be 4..64 and a multiple of CHUNK");
    end

    if (PIPE) begin : g_pipe
        localparam int STAGES = WIDTH / CHUNK;
        for (genvar k = 0; k < STAGES; k++) begin : g_st
            localparam int LO = k * CHUNK;
            localparam int HI = LO + CHUNK;
            logic [WIDTH-1:LO] xa;
            logic [WIDTH-1:LO] xb;
            logic              xc;
            logic              xv;
            logic [CHUNK:0]    part;
            logic [HI-1:0]     ns;
            if (k == 0) begin : g_first
                assign xa = a;
                assign xb = b;
                assign xc = cin;
                assign xv = in_valid;
                assign ns = part[CHUNK-1:0];
            end else begin : g_next
                assign xa = g_st[k-1].g_reg.ba;
                assign xb = g_st[k-1].g_reg.bb;
                assign xc = g_st[k-1].g_reg.bc;
                assign xv = g_st[k-1].g_reg.bv;
                assign ns = {part[CHUNK-1:0], g_st[k-1].g_reg.bs};
            end
            assign part = {1'b0, xa[HI-1:LO]} + {1'b0, xb[HI-1:LO]} + {{CHUNK{1'b0}}, xc};
            if (k < STAGES - 1) begin : g_reg
                logic [WIDTH-1:HI] ba;
                logic [WIDTH-1:HI] bb;
                logic [HI-1:0]     bs;
                logic              bc;
                logic              bv;
                // stage valid: bubbles travel as valid=0
                always_ff @(posedge clk or posedge rst)
                    if (rst) bv <= 1'b0;
                    else if (adv) bv <= xv;
                // skew (pending operand chunks), deskew (resolved sum bits) and carry
                always_ff @(posedge clk)
                    if (adv && xv) begin
                        ba <= xa[WIDTH-1:HI];
                        bb <= xb[WIDTH-1:HI];
                        bs <= ns;
                        bc <= part[CHUNK];
                    end
            end else begin : g_last
                assign fin_v = xv;
                assign fin_s = ns;
                assign fin_c = part[CHUNK];
`ifdef ADDER_OVERFLOW_EN
                assign fin_m = xa[WIDTH-1] ^ xb[WIDTH-1] ^ ns[WIDTH-1];
`endif
            end
        end
    end else begin : g_flat
        logic [WIDTH:0] full;
        assign full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        assign fin_v = in_valid;
        assign fin_s = full[WIDTH-1:0];
        assign fin_c = full[WIDTH];
`ifdef ADDER_OVERFLOW_EN
        assign fin_m = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
`endif
    end

    // output register: data only loads with a valid result, so it holds otherwise
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c         <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_v;
            if (fin_v) begin
                sum <= fin_s;
                c   <= fin_c;
            end
        end

`ifdef ADDER_OVERFLOW_EN
    // overflow = carry into MSB xor carry out of MSB, registered with the sum
    always_ff @(posedge clk or posedge rst)
        if (rst) ovf <= 1'b0;
        else if (adv && fin_v) ovf <= fin_m ^ fin_c;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_adder_nbits_staged.sv
// tb_adder_nbits_staged: drives a pipelined 8-bit, a flat 8-bit and a pipelined 16-bit adder
// with shared stimulus and checks each against an arithmetic reference and scoreboard.
module tb_adder_nbits_staged;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ov [3];
    logic        ir [3];
    logic        cc [3];
    logic        of [3];
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [63:0] sm [3];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       o;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    assign sm[0] = {56'd0, s0};
    assign sm[1] = {56'd0, s1};
    assign sm[2] = {48'd0, s2};

    adder_nbits_staged #(.WIDTH(8), .CHUNK(4), .CLOCK_FREQUENCY(200), .HIGH_SPEED(150)) u_p8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .c(cc[0]), .ovf(of[0]));
    adder_nbits_staged #(.WIDTH(8), .CHUNK(4), .CLOCK_FREQUENCY(50), .HIGH_SPEED(150)) u_n8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .c(cc[1]), .ovf(of[1]));
    adder_nbits_staged #(.WIDTH(16), .CHUNK(4), .CLOCK_FREQUENCY(200), .HIGH_SPEED(150)) u_p16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .cin(cin), .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .c(cc[2]), .ovf(of[2]));

    function automatic int wd(int d);
        return d == 2 ? 16 : 8;
    endfunction

    function automatic int st(int d);
        return d == 0 ? 2 : (d == 1 ? 1 : 4);
    endfunction

    // reference: {ovf, carry, sum} of x+y+ci in w bits
    function automatic logic [65:0] ref_add(int w, logic [63:0] x, logic [63:0] y, logic ci);
        logic [63:0] m;
        logic [63:0] s;
        logic [64:0] t;
        logic        o;
        m = (64'd1 << w) - 64'd1;
        t = {1'b0, x & m} + {1'b0, y & m} + {64'd0, ci};
        s = t[63:0] & m;
        o = 1'b0;
`ifdef ADDER_OVERFLOW_EN
        o = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
`endif
        return {o, t[w], s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic [65:0] q [$];
        logic        stalled = 1'b0;
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk($sformatf("d%0d_held_valid", g), 64'(ov[g]), 64'd1);
                    chk($sformatf("d%0d_held_ready", g), 64'(ir[g]), 64'(out_ready));
                end
                if (ov[g]) begin
                    if (q.size() == 0) chk($sformatf("d%0d_unexpected_out", g), 64'(ov[g]), 64'd0);
                    else begin
                        chk($sformatf("d%0d_sum", g), sm[g], q[0][63:0]);
                        chk($sformatf("d%0d_carry", g), 64'(cc[g]), 64'(q[0][64]));
                        chk($sformatf("d%0d_ovf", g), 64'(of[g]), 64'(q[0][65]));
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (in_valid && ir[g]) q.push_back(ref_add(wd(g), 64'(a), 64'(b), cin));
                stalled = ov[g] && !out_ready;
            end
        end
    end

    task automatic apply_one(input vec_t v, input string tag);
        int          lat [3];
        logic [63:0] vs [3];
        logic        vc [3];
        logic        vo [3];
        logic [65:0] e;
        for (int d = 0; d < 3; d++) lat[d] = 0;
        @(posedge clk);
        #1;
        a = {8'd0, v.a};
        b = {8'd0, v.b};
        cin = v.ci;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                if (ov[d] && lat[d] == 0) begin
                    lat[d] = cyc;
                    vs[d] = sm[d];
                    vc[d] = cc[d];
                    vo[d] = of[d];
                end
        end
        for (int d = 0; d < 3; d++) begin
            e = d == 2 ? ref_add(16, {56'd0, v.a}, {56'd0, v.b}, v.ci) : {1'b0, v.co, 56'd0, v.s};
`ifdef ADDER_OVERFLOW_EN
            if (d != 2) e[65] = v.o;
`endif
            chk($sformatf("%s_d%0d_latency", tag, d), 64'(lat[d]), 64'(st(d)));
            chk($sformatf("%s_d%0d_sum", tag, d), vs[d], e[63:0]);
            chk($sformatf("%s_d%0d_carry", tag, d), 64'(vc[d]), 64'(e[64]));
            chk($sformatf("%s_d%0d_ovf", tag, d), 64'(vo[d]), 64'(e[65]));
        end
    endtask

    task automatic drain_check(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk($sformatf("%s_d0_pending", tag), 64'(g_mon[0].q.size()), 64'd0);
        chk($sformatf("%s_d1_pending", tag), 64'(g_mon[1].q.size()), 64'd0);
        chk($sformatf("%s_d2_pending", tag), 64'(g_mon[2].q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt [3];
        int first [3];
        int last [3];
        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_d%0d_out_valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("reset_d%0d_sum", d), sm[d], 64'd0);
            chk($sformatf("reset_d%0d_carry", d), 64'(cc[d]), 64'd0);
            chk($sformatf("reset_d%0d_ovf", d), 64'(of[d]), 64'd0);
            chk($sformatf("reset_d%0d_in_ready", d), 64'(ir[d]), 64'd1);
        end
        #10;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) apply_one(tbl[i], $sformatf("vec%0d", i));

        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            first[d] = 0;
            last[d] = 0;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            in_valid = i < 16;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                if (ov[d]) begin
                    if (cnt[d] == 0) first[d] = i;
                    last[d] = i;
                    cnt[d]++;
                end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("burst_d%0d_count", d), 64'(cnt[d]), 64'd16);
            chk($sformatf("burst_d%0d_span", d), 64'(last[d] - first[d]), 64'd15);
        end
        drain_check("burst");

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("stall%0d_d%0d_in_ready", i, d), 64'(ir[d]), 64'd0);
                chk($sformatf("stall%0d_d%0d_out_valid", i, d), 64'(ov[d]), 64'd1);
            end
        end
        drain_check("stall");

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
        end
        drain_check("random");

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        @(posedge clk);
        #1;
        a = 16'($urandom);
        b = 16'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_d%0d_out_valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("midrst_d%0d_sum", d), sm[d], 64'd0);
            chk($sformatf("midrst_d%0d_carry", d), 64'(cc[d]), 64'd0);
            chk($sformatf("midrst_d%0d_in_ready", d), 64'(ir[d]), 64'd1);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk($sformatf("stale%0d_d%0d", i, d), 64'(ov[d]), 64'd0);
        end
        apply_one(tbl[4], "post_reset");
        drain_check("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
